// File: rtl/seg7_pattern_rx.sv
// seg7_pattern_rx: snoops an active-low 7-segment bus (bit0=a .. bit6=g),
// waits for a pattern to hold steady, decodes it back to a decimal digit and
// packs accepted digits into a BCD word (first digit in the top nibble).
module seg7_pattern_rx #(
  parameter int STABLE_CYCLES = 4,
  parameter int DIGITS        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic                  seg_valid,
  output logic [3:0]            digit,
  output logic                  digit_valid,
  output logic                  err,
  output logic [4*DIGITS-1:0]   word,
  output logic                  word_valid,
  output logic                  busy
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int DW = $clog2(DIGITS + 1);
  localparam int WW = 4 * DIGITS;
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CYCLES);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DIGITS - 1);
  // A single sample is enough to accept when the filter depth is one.
  localparam bit ONE_SHOT = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {IDLE, STABLE, HOLD} state_t;
  typedef enum logic [1:0] {K_DIGIT, K_BLANK, K_ILLEGAL} kind_t;
  typedef struct packed {
    kind_t      kind;
    logic [3:0] value;
  } decode_t;

  // Patterns are written g..a, so bit6 (segment g) is the leftmost character.
  function automatic decode_t decode(input logic [6:0] pat);
    decode_t r;
    r.kind  = K_DIGIT;
    r.value = 4'd0;
    case (pat)
      7'b1000000: r.value = 4'd0;
      7'b1111001: r.value = 4'd1;
      7'b0100100: r.value = 4'd2;
      7'b0110000: r.value = 4'd3;
      7'b0011001: r.value = 4'd4;
      7'b0010010: r.value = 4'd5;
      7'b0000010: r.value = 4'd6;
      7'b1111000: r.value = 4'd7;
      7'b0000000: r.value = 4'd8;
      7'b0010000: r.value = 4'd9;
      7'b1111111: r.kind  = K_BLANK;
      default:    r.kind  = K_ILLEGAL;
    endcase
    return r;
  endfunction

  state_t          state, state_next;
  logic [6:0]      cap, cap_next;
  logic [CW-1:0]   cnt, cnt_next, cnt_inc;
  logic            accept;
  decode_t         dec;
  logic [WW-1:0]   partial, partial_shift;
  logic [DW-1:0]   dcnt;

  // Every acceptance registers the current sample, so decode seg_in directly.
  assign dec           = decode(seg_in);
  assign partial_shift = (partial << 4) | WW'(dec.value);
  assign cnt_inc       = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign busy          = (state == STABLE);

  // Next-state logic: stability filter and acceptance decision.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    state_next = state;
    cap_next   = cap;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (seg_valid) begin
          cap_next   = seg_in;
          cnt_next   = CW'(1);
          accept     = ONE_SHOT;
          state_next = ONE_SHOT ? HOLD : STABLE;
        end
      end
      STABLE: begin
        if (!seg_valid) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else if (seg_in != cap) begin
          cap_next   = seg_in;
          cnt_next   = CW'(1);
          accept     = ONE_SHOT;
          state_next = ONE_SHOT ? HOLD : STABLE;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            accept     = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (!seg_valid) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else if (seg_in != cap) begin
          cap_next   = seg_in;
          cnt_next   = CW'(1);
          accept     = ONE_SHOT;
          state_next = ONE_SHOT ? HOLD : STABLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register for the filter FSM, capture register and stability count.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so all of them update together at the edge.
    if (reset) begin
      state <= IDLE;
      cap   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cap   <= cap_next;
      cnt   <= cnt_next;
    end
  end

  // Acceptance actions: digit update, word assembly and one-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit       <= '0;
      digit_valid <= 1'b0;
      err         <= 1'b0;
      word        <= '0;
      word_valid  <= 1'b0;
      partial     <= '0;
      dcnt        <= '0;
    end else begin
      digit_valid <= 1'b0;
      word_valid  <= 1'b0;
      err         <= 1'b0;
      if (accept) begin
        case (dec.kind)
          K_DIGIT: begin
            digit       <= dec.value;
            digit_valid <= 1'b1;
            if (dcnt == DCNT_LAST) begin
              word       <= partial_shift;
              word_valid <= 1'b1;
              partial    <= '0;
              dcnt       <= '0;
            end else begin
              partial <= partial_shift;
              dcnt    <= dcnt + 1'b1;
            end
          end
          K_BLANK: begin
            partial <= '0;
            dcnt    <= '0;
          end
          default: begin
            err     <= 1'b1;
            partial <= '0;
            dcnt    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_pattern_rx.sv
// Directed bench for seg7_pattern_rx: expected pulses are queued when a
// pattern is driven and matched by a negedge monitor when the DUT pulses.
module tb_seg7_pattern_rx;

  localparam int STABLE = 4;
  localparam int NDIG   = 4;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010, P7 = 7'b1111000, P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000, PBLANK = 7'b1111111, PILL = 7'b0000001;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic        seg_valid;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        err;
  logic [15:0] word;
  logic        word_valid;
  logic        busy;

  seg7_pattern_rx #(.STABLE_CYCLES(STABLE), .DIGITS(NDIG)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .seg_valid(seg_valid),
    .digit(digit), .digit_valid(digit_valid), .err(err),
    .word(word), .word_valid(word_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    logic        dv;
    logic [3:0]  d;
    logic        wv;
    logic [15:0] w;
    logic        e;
  } ev_t;

  ev_t sb[$];
  ev_t ev;

  // Reference model of the assembled-word behaviour.
  logic [3:0]  m_digit = '0;
  logic [15:0] m_word  = '0;
  logic [15:0] m_part  = '0;
  int          m_cnt   = 0;
  logic [6:0]  tbl [10] = '{P0, P1, P2, P3, P4, P5, P6, P7, P8, P9};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Work out what accepting pat should produce and queue it for cycle at.
  task automatic push_expect(input logic [6:0] pat, input int at);
    ev_t e;
    int  v;
    v = -1;
    for (int i = 0; i < 10; i++) if (tbl[i] == pat) v = i;
    e.cyc = at; e.dv = 1'b0; e.wv = 1'b0; e.e = 1'b0;
    if (v >= 0) begin
      m_digit = 4'(v);
      m_part  = (m_part << 4) | 16'(v);
      m_cnt++;
      e.dv = 1'b1;
      if (m_cnt == NDIG) begin
        m_word = m_part;
        e.wv   = 1'b1;
        m_part = '0;
        m_cnt  = 0;
      end
      e.d = m_digit; e.w = m_word;
      sb.push_back(e);
    end else if (pat == PBLANK) begin
      m_part = '0;
      m_cnt  = 0;
    end else begin
      m_part = '0;
      m_cnt  = 0;
      e.e = 1'b1; e.d = m_digit; e.w = m_word;
      sb.push_back(e);
    end
  endtask

  // Drive one pattern for n cycles; acc says this run should be accepted.
  task automatic hold(input logic [6:0] pat, input logic v, input int n, input bit acc);
    int start;
    start     = cyc;
    seg_in    = pat;
    seg_valid = v;
    if (acc) push_expect(pat, start + STABLE);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    seg_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    reset   = 1'b0;
    m_digit = '0;
    m_word  = '0;
    m_part  = '0;
    m_cnt   = 0;
  endtask

  // Scoreboard monitor: every pulse must match the head of the queue, and a
  // queued pulse whose cycle has arrived without a pulse is reported missing.
  always @(negedge clk) begin
    if (digit_valid === 1'b1 || word_valid === 1'b1 || err === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'd0, digit_valid, word_valid, err}, 32'd0);
      end else begin
        ev = sb.pop_front();
        check("pulse_cycle", cyc, ev.cyc);
        check("digit_valid", {31'd0, digit_valid}, {31'd0, ev.dv});
        check("digit", {28'd0, digit}, {28'd0, ev.d});
        check("word_valid", {31'd0, word_valid}, {31'd0, ev.wv});
        check("word", {16'd0, word}, {16'd0, ev.w});
        check("err", {31'd0, err}, {31'd0, ev.e});
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      ev = sb.pop_front();
      check("missed_pulse_cycle", cyc, -1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    seg_valid = 1'b0;
    seg_in    = PBLANK;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset: every output stays zero.
    for (int i = 0; i < 10; i++) begin
      check("idle_outputs", {8'd0, digit, digit_valid, err, word, word_valid, busy}, 32'd0);
      hold(PBLANK, 1'b0, 1, 1'b0);
    end

    // Digit 2 held: one accept after four samples, then silence while held.
    hold(P2, 1'b1, 1, 1'b1);
    check("busy_counting", {31'd0, busy}, 32'd1);
    hold(P2, 1'b1, 3, 1'b0);
    check("busy_in_hold", {31'd0, busy}, 32'd0);
    hold(P2, 1'b1, 20, 1'b0);
    check("digit_after_hold", {28'd0, digit}, {28'd0, m_digit});

    // Glitch to 1 restarts the count; only 3 is accepted.
    hold(P3, 1'b1, 3, 1'b0);
    hold(P1, 1'b1, 1, 1'b0);
    hold(P3, 1'b1, 4, 1'b1);

    // Blank discards the partial 2,3 so the next word is exactly 1234.
    hold(PBLANK, 1'b1, 4, 1'b1);
    hold(P1, 1'b1, 4, 1'b1);
    hold(P2, 1'b1, 4, 1'b1);
    hold(P3, 1'b1, 4, 1'b1);
    hold(P4, 1'b1, 4, 1'b1);
    hold(P4, 1'b1, 2, 1'b0);
    check("word_1234", {16'd0, word}, 32'h1234);

    // Illegal pattern after two digits: err, digit kept, partial dropped.
    hold(P5, 1'b1, 4, 1'b1);
    hold(P6, 1'b1, 4, 1'b1);
    hold(PILL, 1'b1, 4, 1'b1);
    hold(PILL, 1'b1, 2, 1'b0);
    check("digit_after_err", {28'd0, digit}, 32'd6);
    hold(P9, 1'b1, 4, 1'b1);
    hold(P8, 1'b1, 4, 1'b1);
    hold(P7, 1'b1, 4, 1'b1);
    hold(P6, 1'b1, 4, 1'b1);
    hold(P6, 1'b1, 2, 1'b0);
    check("word_9876", {16'd0, word}, 32'h9876);

    // seg_valid dropped part-way through a hold: no pulse, back to IDLE.
    hold(P8, 1'b1, 2, 1'b0);
    check("busy_before_drop", {31'd0, busy}, 32'd1);
    hold(P8, 1'b0, 1, 1'b0);
    check("busy_after_drop", {31'd0, busy}, 32'd0);
    hold(P8, 1'b0, 1, 1'b0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    hold(P8, 1'b1, 4, 1'b1);

    // Reset mid-word and mid-count; the next word needs four fresh digits.
    hold(P1, 1'b1, 4, 1'b1);
    hold(P2, 1'b1, 4, 1'b1);
    hold(P3, 1'b1, 2, 1'b0);
    do_reset(1);
    check("outputs_after_reset", {8'd0, digit, digit_valid, err, word, word_valid, busy}, 32'd0);
    hold(P5, 1'b1, 4, 1'b1);
    hold(P6, 1'b1, 4, 1'b1);
    hold(P7, 1'b1, 4, 1'b1);
    hold(P8, 1'b1, 4, 1'b1);
    hold(PBLANK, 1'b0, 6, 1'b0);
    check("word_5678", {16'd0, word}, 32'h5678);
    check("sb_drain", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_pattern_rx.md
Name: seg7_pattern_rx

Overview:
- Receive-side counterpart of the board's digit-to-segment drivers. Snoops an active-low 7-segment pattern bus (bit0 = segment a … bit6 = segment g).
- Filters each pattern for stability and decodes it back to a decimal digit. Invalid patterns are flagged.
- Accepted digits are assembled into a multi-digit BCD word. Used by the CRC network controller lab to read back display traffic and self-check it.

Parameters:
- STABLE_CYCLES, 4, consecutive identical valid samples required before a pattern is accepted (legal range ≥1).
- DIGITS, 4, digits per assembled BCD word (legal range ≥1).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- seg_in  input  7  active-low segment pattern, bit0=a … bit6=g
- seg_valid  input  1  seg_in is meaningful this cycle
- digit  output  4  last accepted digit, binary 0-9
- digit_valid  output  1  one-cycle pulse: digit just updated
- err  output  1  one-cycle pulse: a stable pattern was not a legal digit
- word  output  4*DIGITS  last completed BCD word; first-received digit is in the most significant nibble
- word_valid  output  1  one-cycle pulse: word just updated
- busy  output  1  high while the state is STABLE

Behaviour:
- Reset (synchronous, overrides every other event in the same cycle): all outputs are 0, state = IDLE, capture register = 0, stability count = 0, partial word and digit count are cleared. Reset mid-word discards the partial word with no pulse.
- Decode table (seg_in -> digit):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4
  - 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9
  - 1111111 = BLANK.
  - Every other pattern is ILLEGAL.
- A sample is a cycle with seg_valid=1.
- State machine (IDLE, STABLE, HOLD):
  - IDLE:
    - sample -> capture seg_in, count = 1, go to STABLE.
    - Otherwise stay in IDLE.
  - STABLE:
    - seg_valid=0 -> IDLE, count is discarded, no pulse.
    - Sample differing from the captured pattern -> recapture, count = 1, stay in STABLE.
    - Sample equal to the captured pattern -> count + 1.
  - Acceptance: happens at the edge that registers the STABLE_CYCLES-th consecutive equal sample, then the state goes to HOLD. With STABLE_CYCLES=1, the first sample accepts directly from IDLE or HOLD.
  - HOLD:
    - Equal sample -> ignored; a held pattern is never accepted twice.
    - Differing sample -> recapture, count = 1, go to STABLE.
    - seg_valid=0 -> IDLE.
- Action on acceptance (pulses are high in the cycle after the accepting edge and last exactly 1 cycle):
  - Legal digit:
    - digit <= decoded value, digit_valid pulse.
    - Shift the partial word left 4 bits and insert the digit in the low nibble; digit count + 1.
    - When the digit count reaches DIGITS: word <= assembled value, word_valid pulse in the same cycle as that digit_valid, then the partial word and count clear.
  - BLANK: clears the partial word and digit count. No pulse; digit and word are unchanged.
  - ILLEGAL: err pulse, clears the partial word and digit count. digit and word are unchanged.
- Latency: the pulse appears STABLE_CYCLES cycles after the first cycle of the new pattern. Example: STABLE_CYCLES=4, pattern on cycles 0-3, pulse on cycle 4.
- Back-to-back: a new differing pattern sampled on the pulse cycle starts counting that cycle. Minimum accept spacing is STABLE_CYCLES cycles.
- Count width is clog2(STABLE_CYCLES+1) bits and saturates; it never wraps.
- Pulses never overlap except digit_valid with word_valid.
- busy = 1 exactly while the state is STABLE.

Test Plan:
- Reset then idle: all outputs 0 for 10 cycles. Assert reset while mid-STABLE and mid-word -> next word requires a full DIGITS new digits.
- STABLE_CYCLES=4: hold 0100100 for 4 cycles -> digit=2 with digit_valid on cycle 4 only. Hold the same pattern 20 more cycles -> no further pulses.
- Glitch: 0110000 for 3 cycles, 1111001 for 1 cycle, 0110000 for 4 cycles -> single accept, digit=3; no accept of 1.
- DIGITS=4: stable 1111001, 0100100, 0110000, 0011001 separated by value changes -> word=16'h1234, word_valid coincident with the fourth digit_valid.
- Illegal 0000001 stable 4 cycles after two digits -> err pulse, digit unchanged. Then four digits 9,8,7,6 -> word=16'h9876.
- seg_valid dropped on cycle 2 of a 4-cycle hold -> no pulse, busy falls, state IDLE. BLANK 1111111 mid-word -> partial word discarded, no pulse.
